// File: rtl/token_tx_scheduler_if.sv
// token_tx_scheduler_if
//   Request/acknowledge handshake between the token transmit scheduler and
//   the TX handshake stage.
//   tx_req          scheduler -> TX stage : a word is selected and should be sent
//   tx_data_select  scheduler -> TX stage : TX mux select (0 = buffer, 2 = token)
//   tx_ack          TX stage -> scheduler : selected word accepted (transfer on tx_req & tx_ack)
interface token_tx_scheduler_if;
   logic       tx_req;
   logic       tx_ack;
   logic [2:0] tx_data_select;

   modport master (
      output tx_req,
      output tx_data_select,
      input  tx_ack
   );

   modport slave (
      input  tx_req,
      input  tx_data_select,
      output tx_ack
   );
endinterface

// File: rtl/token_tx_scheduler.sv
// token_tx_scheduler
//   Sequences the router's transmit path while it holds the ring token: sends
//   the pending node packet, waits for ACK/NACK, retransmits on NACK or
//   response timeout up to MAX_RETRY times, then forwards the token.
//
//   Clk_R           in   clock, rising edge
//   Rst_n           in   asynchronous reset, active-low
//   token_rcvd      in   pulse: TOKEN decoded for this router
//   pkt_pending     in   level: packet buffer holds an unsent node packet
//   ack_rcvd        in   pulse: ACK decoded
//   nack_rcvd       in   pulse: NACK decoded
//   tx              if   TX handshake (tx_req / tx_ack / tx_data_select), master side
//   buffer_release  out  pulse: buffer entry consumed (delivered or dropped)
//   drop_err        out  pulse: packet dropped after the retry limit
//   token_err       out  pulse: token_rcvd seen outside IDLE
//   token_held      out  level: this router owns the token
//   retry_cnt       out  retransmissions done for the current packet
module token_tx_scheduler #(
   parameter int unsigned TIMEOUT   = 64,
   parameter int unsigned TO_W      = 8,
   parameter int unsigned MAX_RETRY = 3,
   parameter int unsigned RC_W      = 2
) (
   input  logic                 Clk_R,
   input  logic                 Rst_n,
   input  logic                 token_rcvd,
   input  logic                 pkt_pending,
   input  logic                 ack_rcvd,
   input  logic                 nack_rcvd,
   token_tx_scheduler_if.master tx,
   output logic                 buffer_release,
   output logic                 drop_err,
   output logic                 token_err,
   output logic                 token_held,
   output logic [RC_W-1:0]      retry_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      SEND_PKT,
      WAIT_RSP,
      SEND_TOK
   } state_t;

   localparam logic [2:0] SEL_BUF = 3'd0;
   localparam logic [2:0] SEL_TOK = 3'd2;

   state_t          state_q;
   logic            tx_req_q;
   logic [2:0]      tx_sel_q;
   logic            buffer_release_q;
   logic            drop_err_q;
   logic            token_err_q;
   logic            token_held_q;
   logic [RC_W-1:0] retry_cnt_q;
   logic [TO_W-1:0] timer_q;

   logic transfer;
   logic timeout_hit;
   logic retry_left;

   assign transfer    = tx_req_q & tx.tx_ack;
   assign timeout_hit = (timer_q == TO_W'(TIMEOUT - 1));
   assign retry_left  = (retry_cnt_q < RC_W'(MAX_RETRY));

   always_ff @(posedge Clk_R or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q          <= IDLE;
         tx_req_q         <= 1'b0;
         tx_sel_q         <= SEL_BUF;
         buffer_release_q <= 1'b0;
         drop_err_q       <= 1'b0;
         token_err_q      <= 1'b0;
         token_held_q     <= 1'b0;
         retry_cnt_q      <= '0;
         timer_q          <= '0;
      end else begin
         buffer_release_q <= 1'b0;
         drop_err_q       <= 1'b0;
         // A token while already busy is reported but never disturbs the sequence.
         token_err_q      <= token_rcvd && (state_q != IDLE);

         case (state_q)
            IDLE: begin
               tx_req_q <= 1'b0;
               if (token_rcvd) begin
                  token_held_q <= 1'b1;
                  tx_req_q     <= 1'b1;
                  if (pkt_pending) begin
                     state_q     <= SEND_PKT;
                     tx_sel_q    <= SEL_BUF;
                     retry_cnt_q <= '0;
                  end else begin
                     state_q  <= SEND_TOK;
                     tx_sel_q <= SEL_TOK;
                  end
               end
            end

            SEND_PKT: begin
               if (transfer) begin
                  state_q  <= WAIT_RSP;
                  tx_req_q <= 1'b0;
                  timer_q  <= '0;
               end
            end

            WAIT_RSP: begin
               // Saturating count; the timeout compare above fires before saturation.
               if (timer_q != '1) begin
                  timer_q <= timer_q + 1'b1;
               end
               if (ack_rcvd) begin
                  buffer_release_q <= 1'b1;
                  state_q          <= SEND_TOK;
                  tx_req_q         <= 1'b1;
                  tx_sel_q         <= SEL_TOK;
               end else if (nack_rcvd || timeout_hit) begin
                  tx_req_q <= 1'b1;
                  if (retry_left) begin
                     retry_cnt_q <= retry_cnt_q + 1'b1;
                     state_q     <= SEND_PKT;
                     tx_sel_q    <= SEL_BUF;
                  end else begin
                     drop_err_q       <= 1'b1;
                     buffer_release_q <= 1'b1;
                     state_q          <= SEND_TOK;
                     tx_sel_q         <= SEL_TOK;
                  end
               end
            end

            SEND_TOK: begin
               if (transfer) begin
                  state_q      <= IDLE;
                  tx_req_q     <= 1'b0;
                  token_held_q <= 1'b0;
                  retry_cnt_q  <= '0;
               end
            end

            default: begin
               state_q  <= IDLE;
               tx_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign tx.tx_req         = tx_req_q;
   assign tx.tx_data_select = tx_sel_q;
   assign buffer_release    = buffer_release_q;
   assign drop_err          = drop_err_q;
   assign token_err         = token_err_q;
   assign token_held        = token_held_q;
   assign retry_cnt         = retry_cnt_q;

endmodule
